// File: rtl/dff_reg_arbiter.sv
// dff_reg_arbiter
//   Round-robin arbiter that shares one WIDTH-bit register among NREQ write
//   requesters. One requester owns the register at a time and may load it
//   once per cycle. Ownership ends when the owner drops its request or after
//   MAX_HOLD writes. Every handover passes through one IDLE cycle.
//
//   Optional build macro: DFF_REG_ARBITER_LOCK_EN
//     When defined, an extra 'lock' input lets the owner hold the register
//     past MAX_HOLD writes. The hold count saturates at MAX_HOLD. Release then
//     happens on a dropped request, or on the first unlocked write.
//     When undefined, there is no 'lock' port and forced release always applies.
module dff_reg_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4,
  parameter int IDW      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef DFF_REG_ARBITER_LOCK_EN
  input  logic                  lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      Q,
  output logic [WIDTH-1:0]      Qbar,
  output logic                  busy,
  output logic [IDW-1:0]        owner
);

  // Two-state controller: waiting for a request, or serving one owner.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // The hold counter has one spare bit so that count+1 never wraps,
  // even at MAX_HOLD = 15.
  localparam int                CNT_W    = 5;
  localparam logic [CNT_W-1:0]  HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [IDW-1:0]    LAST_RST = IDW'(NREQ - 1);

  // Registered state.
  logic [0:0]       r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [WIDTH-1:0] r_q;
  logic [IDW-1:0]   r_owner;
  logic [IDW-1:0]   r_last;
  logic [CNT_W-1:0] r_cnt;

  // Next-state helpers.
  logic             w_pick_vld;
  logic [IDW-1:0]   w_pick_idx;
  logic             w_own_req;
  logic             w_wr_en;
  logic [WIDTH-1:0] w_wsel;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_limit;
  logic             w_release;

  // Round-robin search. Candidates are tried in the order last+1, last+2,
  // and so on, modulo NREQ. The loop runs from the farthest candidate down
  // to the nearest, so the nearest requester is the one that remains.
  // Result: {found, index}.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r,
                                           input logic [IDW-1:0]  last);
    logic [IDW:0]   res;
    logic [IDW-1:0] ix;
    int             cand;
    res = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = (int'(last) + k) % NREQ;
      ix   = cand[IDW-1:0];
      if (r[ix]) res = {1'b1, ix};
    end
    return res;
  endfunction

  // Combinational decisions: next owner in IDLE, write enable, hold count
  // and release condition in GRANT.
  always_comb begin
    {w_pick_vld, w_pick_idx} = rr_pick(req, r_last);
    w_own_req  = req[r_owner];
    w_wr_en    = (r_state == ST_GRANT) && w_own_req;
    w_wsel     = wdata[r_owner*WIDTH +: WIDTH];
    w_cnt_inc  = r_cnt + CNT_W'(1);
`ifdef DFF_REG_ARBITER_LOCK_EN
    // The count saturates at MAX_HOLD while locked. An unlocked write at or
    // past the limit releases the register.
    w_limit    = (w_cnt_inc >= HOLD_MAX);
    w_cnt_next = w_limit ? HOLD_MAX : w_cnt_inc;
    w_release  = (r_state == ST_GRANT) && (!w_own_req || (w_limit && !lock));
`else
    w_limit    = (w_cnt_inc == HOLD_MAX);
    w_cnt_next = w_cnt_inc;
    w_release  = (r_state == ST_GRANT) && (!w_own_req || w_limit);
`endif
  end

  // State, grant, owner and shared-register update. Reset overrides
  // everything, including a write that would otherwise happen this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_q     <= '0;
      r_owner <= '0;
      r_last  <= LAST_RST;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_state <= ST_GRANT;
            r_gnt   <= NREQ'(1) << w_pick_idx;
            r_owner <= w_pick_idx;
            r_last  <= w_pick_idx;
            r_cnt   <= '0;
          end
        end
        ST_GRANT: begin
          if (w_wr_en) begin
            r_q   <= w_wsel;
            r_cnt <= w_cnt_next;
          end
          if (w_release) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  // Every output comes straight from a register. The only logic on an
  // output path is the inverter that produces Qbar.
  assign gnt   = r_gnt;
  assign Q     = r_q;
  assign Qbar  = ~r_q;
  assign busy  = (r_state == ST_GRANT);
  assign owner = r_owner;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Testbench for dff_reg_arbiter. A behavioural model predicts the visible
// state after each clock edge, and a monitor compares it with the DUT.
module tb_dff_reg_arbiter;
  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;
  localparam int IDW      = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic                  lock;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      Q;
  logic [WIDTH-1:0]      Qbar;
  logic                  busy;
  logic [IDW-1:0]        owner;

  dff_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
`ifdef DFF_REG_ARBITER_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .Q     (Q),
    .Qbar  (Qbar),
    .busy  (busy),
    .owner (owner)
  );

  typedef struct packed {
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic [IDW-1:0]   owner;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: who owns the register, how many writes the owner
  // has made, which requester was granted last, and the register value.
  bit               m_busy   = 0;
  int               m_owner  = 0;
  int               m_last   = NREQ - 1;
  int               m_writes = 0;
  logic [WIDTH-1:0] m_q      = '0;

  function automatic void model_step(input logic r, input logic [NREQ-1:0] rq,
                                     input logic [NREQ*WIDTH-1:0] wd, input logic lk);
    logic [IDW-1:0] ix;
    int             cand;
    if (r) begin
      m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_writes = 0; m_q = '0;
      return;
    end
    if (!m_busy) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = (m_last + k) % NREQ;
        ix   = IDW'(cand);
        if (rq[ix]) begin
          m_busy = 1; m_owner = cand; m_last = cand; m_writes = 0;
          break;
        end
      end
    end else begin
      ix = IDW'(m_owner);
      if (rq[ix]) begin
        m_q = wd[m_owner*WIDTH +: WIDTH];
        if (lk) begin
          if (m_writes < MAX_HOLD) m_writes++;
        end else begin
          m_writes++;
          if (m_writes >= MAX_HOLD) m_busy = 0;
        end
      end else begin
        m_busy = 0;
      end
    end
  endfunction

  function automatic logic [NREQ*WIDTH-1:0] rnd_wd();
    logic [NREQ*WIDTH-1:0] v;
    for (int j = 0; j < NREQ; j++) v[j*WIDTH +: WIDTH] = WIDTH'($urandom);
    return v;
  endfunction

  // Apply one cycle of stimulus, push the expected post-edge state, and
  // advance to the next falling edge.
  task automatic drive(input logic r, input logic [NREQ-1:0] rq,
                       input logic [NREQ*WIDTH-1:0] wd, input logic lk);
    exp_t e;
    rst = r; req = rq; wdata = wd; lock = lk;
`ifndef DFF_REG_ARBITER_LOCK_EN
    lk = 1'b0;
`endif
    model_step(r, rq, wd, lk);
    e.gnt   = m_busy ? (NREQ'(1) << m_owner) : '0;
    e.q     = m_q;
    e.busy  = m_busy;
    e.owner = IDW'(m_owner);
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: the DUT presents new state after every rising edge. Each
  // sample consumes one prediction from the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (gnt !== e.gnt || Q !== e.q || Qbar !== ~e.q ||
            busy !== e.busy || owner !== e.owner) begin
          bad++;
          $display("FAIL scoreboard t=%0t: got gnt=%b Q=%h Qbar=%h busy=%b owner=%0d, want gnt=%b Q=%h Qbar=%h busy=%b owner=%0d",
                   $time, gnt, Q, Qbar, busy, owner, e.gnt, e.q, ~e.q, e.busy, e.owner);
        end
      end
    end
  end

  initial begin
    logic [NREQ*WIDTH-1:0] wd;
    logic [NREQ-1:0]       rq;
    logic                  lk;
    rst = 1'b1; req = '0; wdata = '0; lock = 1'b0;

    // Reset with every requester active, then release reset.
    repeat (2) drive(1'b1, 4'b1111, rnd_wd(), 1'b0);
    repeat (6) drive(1'b0, 4'b1111, rnd_wd(), 1'b0);
    repeat (3) drive(1'b0, 4'b0000, rnd_wd(), 1'b0);

    // Single write by requester 2.
    wd = rnd_wd(); wd[2*WIDTH +: WIDTH] = 8'hA5;
    repeat (2) drive(1'b0, 4'b0100, wd, 1'b0);
    repeat (3) drive(1'b0, 4'b0000, rnd_wd(), 1'b0);

    // Forced release: requester 1 holds its request with incrementing data.
    for (int k = 1; k <= 9; k++) begin
      wd = rnd_wd(); wd[1*WIDTH +: WIDTH] = WIDTH'(k);
      drive(1'b0, 4'b0010, wd, 1'b0);
    end
    drive(1'b0, 4'b0000, rnd_wd(), 1'b0);

    // Make requester 0 the last grantee, then run the 1011 round-robin.
    repeat (2) drive(1'b0, 4'b0001, rnd_wd(), 1'b0);
    drive(1'b0, 4'b0000, rnd_wd(), 1'b0);
    repeat (24) drive(1'b0, 4'b1011, rnd_wd(), 1'b0);
    repeat (2) drive(1'b0, 4'b0000, rnd_wd(), 1'b0);

    // Reset in the middle of requester 3's grant.
    drive(1'b0, 4'b1000, rnd_wd(), 1'b0);
    wd = rnd_wd(); wd[3*WIDTH +: WIDTH] = 8'h3C;
    drive(1'b1, 4'b1000, wd, 1'b0);
    repeat (3) drive(1'b0, 4'b1111, rnd_wd(), 1'b0);
    repeat (2) drive(1'b0, 4'b0000, rnd_wd(), 1'b0);

`ifdef DFF_REG_ARBITER_LOCK_EN
    // Locked owner: seven locked writes, then one unlocked write.
    drive(1'b0, 4'b0001, rnd_wd(), 1'b1);
    repeat (7) drive(1'b0, 4'b0001, rnd_wd(), 1'b1);
    drive(1'b0, 4'b0001, rnd_wd(), 1'b0);
    repeat (2) drive(1'b0, 4'b0000, rnd_wd(), 1'b0);
`endif

    // Random traffic. Requests are sticky, so grants run long enough to
    // reach the hold limit; reset is asserted occasionally.
    rq = '0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) rq = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      lk = ($urandom_range(0, 2) == 0);
      drive(($urandom_range(0, 49) == 0), rq, rnd_wd(), lk);
    end

    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d predictions left unchecked, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
